// File: rtl/utils_top.sv
// rtl/utils_top.sv - shared opcodes, load encodings and state type for the writeback stage
// Contents: OP_* opcodes, F3_* load funct3 encodings, INST_NOP, wb_state_t.
package utils_top;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // addi x0,x0,0: decode writes the regfile unconditionally, so idle cycles target x0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_ldfmt.sv
// rtl/writeback_ldfmt.sv - load data alignment, extension and error detection
// Ports: funct3/offset select the access, rdat is the raw word, dat the formatted
//        result (0 on error), err flags misaligned or unsupported encodings.
module writeback_ldfmt
    import utils_top::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdat,
    output logic [31:0] dat,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0: byte_sel = rdat[7:0];
            2'd1: byte_sel = rdat[15:8];
            2'd2: byte_sel = rdat[23:16];
            2'd3: byte_sel = rdat[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset[1] ? rdat[31:16] : rdat[15:0];
    end

    always_comb begin
        dat = 32'h0;
        err = 1'b0;
        case (funct3)
            F3_LB:  dat = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: dat = {24'h0, byte_sel};
            F3_LH: begin
                if (offset[0]) err = 1'b1;
                else           dat = {{16{half_sel[15]}}, half_sel};
            end
            F3_LHU: begin
                if (offset[0]) err = 1'b1;
                else           dat = {16'h0, half_sel};
            end
            F3_LW: begin
                if (offset != 2'd0) err = 1'b1;
                else                dat = rdat;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_top.sv
// rtl/writeback_top.sv - writeback stage: commits results, waits for load data with timeout
// Ports: clk/rst (async active-high); mem_vld/mem_rdy/mem_inst/mem_res from memory stage;
//        dmem_rvld/dmem_rdat load response; wb_inst/wb_dat/wb_vld/wb_err registered commit.
module writeback_top
    import utils_top::*;
#(
    parameter int TMO_CYC = 15
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_vld,
    output logic        mem_rdy,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_res,
    input  logic        dmem_rvld,
    input  logic [31:0] dmem_rdat,
    output logic [31:0] wb_inst,
    output logic [31:0] wb_dat,
    output logic        wb_vld,
    output logic        wb_err
);

    localparam int CNT_W = $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

    wb_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ld_inst;
    logic [1:0]       ld_off;   // only the byte offset of the load address matters here
    logic [31:0]      fmt_dat;
    logic             fmt_err;

    assign mem_rdy = (state == IDLE);

    writeback_ldfmt u_ldfmt (
        .funct3 (ld_inst[14:12]),
        .offset (ld_off),
        .rdat   (dmem_rdat),
        .dat    (fmt_dat),
        .err    (fmt_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ld_inst <= INST_NOP;
            ld_off  <= 2'd0;
            wb_inst <= INST_NOP;
            wb_dat  <= 32'h0;
            wb_vld  <= 1'b0;
            wb_err  <= 1'b0;
        end else begin
            wb_inst <= INST_NOP;
            wb_dat  <= 32'h0;
            wb_vld  <= 1'b0;
            wb_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // dmem_rvld is deliberately ignored here: any response is stale
                    if (mem_vld) begin
                        if (mem_inst[6:0] == OP_LOAD) begin
                            state   <= LOAD_WAIT;
                            cnt     <= '0;
                            ld_inst <= mem_inst;
                            ld_off  <= mem_res[1:0];
                        end else begin
                            wb_inst <= mem_inst;
                            wb_dat  <= mem_res;
                            wb_vld  <= 1'b1;
                        end
                    end
                end
                LOAD_WAIT: begin
                    // a response arriving on the last allowed cycle still wins
                    if (dmem_rvld) begin
                        state   <= IDLE;
                        wb_inst <= ld_inst;
                        wb_dat  <= fmt_dat;
                        wb_err  <= fmt_err;
                        wb_vld  <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        wb_inst <= ld_inst;
                        wb_err  <= 1'b1;
                        wb_vld  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_top.sv
// tb/tb_writeback_top.sv - scoreboard bench for writeback_top with directed vectors
module tb_writeback_top;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_vld = 1'b0;
    logic        mem_rdy;
    logic [31:0] mem_inst = 32'h0;
    logic [31:0] mem_res = 32'h0;
    logic        dmem_rvld = 1'b0;
    logic [31:0] dmem_rdat = 32'h0;
    logic [31:0] wb_inst;
    logic [31:0] wb_dat;
    logic        wb_vld;
    logic        wb_err;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] dat;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;

    writeback_top #(.TMO_CYC(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_vld   (mem_vld),
        .mem_rdy   (mem_rdy),
        .mem_inst  (mem_inst),
        .mem_res   (mem_res),
        .dmem_rvld (dmem_rvld),
        .dmem_rdat (dmem_rdat),
        .wb_inst   (wb_inst),
        .wb_dat    (wb_dat),
        .wb_vld    (wb_vld),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every commit must match the head of the scoreboard at the expected cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (wb_vld) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_commit cyc=%0d inst=%h dat=%h err=%b", cyc, wb_inst, wb_dat, wb_err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (wb_inst !== e.inst || wb_dat !== e.dat || wb_err !== e.err || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL commit got inst=%h dat=%h err=%b cyc=%0d expected inst=%h dat=%h err=%b cyc=%0d",
                                 wb_inst, wb_dat, wb_err, cyc, e.inst, e.dat, e.err, e.cyc);
                    end
                end
            end else if (wb_inst !== NOP || wb_dat !== 32'h0 || wb_err !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs got inst=%h dat=%h err=%b expected inst=%h dat=0 err=0",
                         wb_inst, wb_dat, wb_err, NOP);
            end
        end
    end

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Present one instruction and hold it through its accept edge; mem_vld stays high
    task automatic issue(input logic [31:0] inst, input logic [31:0] res);
        for (int i = 0; i < 50 && !mem_rdy; i++) @(posedge clk);
        if (!mem_rdy) begin
            checks++;
            errors++;
            $display("FAIL issue_wait mem_rdy got=0 expected=1");
        end
        mem_vld  = 1'b1;
        mem_inst = inst;
        mem_res  = res;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (inst[6:0] != 7'b0000011) sb.push_back('{inst, res, 1'b0, acc_cyc});
    endtask

    task automatic release_vld();
        mem_vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending got=%0d expected=0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
        check1("mem_rdy_after", {31'h0, mem_rdy}, 32'h1);
    endtask

    // d = edges after accept at which dmem_rvld is sampled; d=0 means never respond
    task automatic load(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] rdat,
                        input int d, input logic [31:0] exp_dat, input logic exp_err);
        issue(inst, res);
        release_vld();
        if (d == 0) begin
            sb.push_back('{inst, 32'h0, 1'b1, acc_cyc + 15});
            for (int k = 1; k < 15; k++) begin
                check1("mem_rdy_tmo_wait", {31'h0, mem_rdy}, 32'h0);
                @(posedge clk);
                #1;
            end
        end else begin
            for (int k = 1; k < d; k++) begin
                check1("mem_rdy_ld_wait", {31'h0, mem_rdy}, 32'h0);
                @(posedge clk);
                #1;
            end
            check1("mem_rdy_ld_wait", {31'h0, mem_rdy}, 32'h0);
            sb.push_back('{inst, exp_dat, exp_err, acc_cyc + d});
            dmem_rvld = 1'b1;
            dmem_rdat = rdat;
            @(posedge clk);
            #1;
            dmem_rvld = 1'b0;
        end
        drain();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check1("reset_wb_inst", wb_inst, NOP);
        check1("reset_wb_dat", wb_dat, 32'h0);
        check1("reset_wb_vld", {31'h0, wb_vld}, 32'h0);
        check1("reset_mem_rdy", {31'h0, mem_rdy}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single non-load, then idle
        issue(32'h0020_81B3, 32'h0000_1234);
        release_vld();
        drain();

        // back-to-back: add, store, jal -> one commit per cycle
        issue(32'h0020_81B3, 32'h0000_0001);
        issue(32'h0020_A223, 32'h0000_1004);
        issue(32'h0080_00EF, 32'h0000_0104);
        release_vld();
        drain();

        // loads: lb, lhu, lh, lbu, misaligned lw, misaligned lh, bad funct3
        load(32'h0000_8303, 32'h0000_1003, 32'h80FF_1234, 3,  32'hFFFF_FF80, 1'b0);
        load(32'h0000_D383, 32'h0000_1002, 32'h8001_5555, 1,  32'h0000_8001, 1'b0);
        load(32'h0000_9383, 32'h0000_1002, 32'h8001_5555, 2,  32'hFFFF_8001, 1'b0);
        load(32'h0000_C303, 32'h0000_1000, 32'h80FF_1234, 1,  32'h0000_0034, 1'b0);
        load(32'h0000_A283, 32'h0000_1001, 32'hDEAD_BEEF, 2,  32'h0000_0000, 1'b1);
        load(32'h0000_9383, 32'h0000_1001, 32'hDEAD_BEEF, 1,  32'h0000_0000, 1'b1);
        load(32'h0000_B283, 32'h0000_1000, 32'hDEAD_BEEF, 1,  32'h0000_0000, 1'b1);

        // timeout, then response on the last allowed cycle
        load(32'h0000_A283, 32'h0000_1000, 32'h0, 0, 32'h0, 1'b1);
        load(32'h0000_A283, 32'h0000_1000, 32'h1234_5678, 15, 32'h1234_5678, 1'b0);

        // spurious response while idle is ignored
        dmem_rvld = 1'b1;
        dmem_rdat = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        dmem_rvld = 1'b0;
        repeat (3) @(posedge clk);

        // reset mid-load abandons it; later response is ignored
        issue(32'h0000_8303, 32'h0000_1003);
        release_vld();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check1("rst_mid_mem_rdy", {31'h0, mem_rdy}, 32'h1);
        check1("rst_mid_wb_inst", wb_inst, NOP);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem_rvld = 1'b1;
        dmem_rdat = 32'h80FF_1234;
        @(posedge clk);
        #1;
        dmem_rvld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("after_rst_wb_inst", wb_inst, NOP);
        check1("after_rst_mem_rdy", {31'h0, mem_rdy}, 32'h1);

        // pipeline still works after the abandoned load
        issue(32'h0020_81B3, 32'h0000_00AA);
        release_vld();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
